// File: rtl/enemy_fire_if.sv
// Handshake/bus bundle between the enemy bullet engine and its consumers
// (draw path, game-control FSM). Clock and reset stay plain ports.
interface enemy_fire_if;
  logic       i_enable;
  logic [7:0] i_x_val_enemy;
  logic [7:0] i_x_val_ship;
  logic [7:0] o_x_val_bullet;
  logic [7:0] o_y_val_bullet;
  logic       o_bullet_active;
  logic       o_hit;
  logic [1:0] o_lives;
  logic       o_game_over;

  modport master (
    output i_enable, i_x_val_enemy, i_x_val_ship,
    input  o_x_val_bullet, o_y_val_bullet, o_bullet_active, o_hit, o_lives, o_game_over
  );

  modport slave (
    input  i_enable, i_x_val_enemy, i_x_val_ship,
    output o_x_val_bullet, o_y_val_bullet, o_bullet_active, o_hit, o_lives, o_game_over
  );
endinterface

// File: rtl/enemy_fire.sv
// Enemy bullet engine: fires downward from the enemy, detects ship hits, tracks lives.
// Optional macro RANDOM_FIRE_EN gates firing with an 8-bit LFSR; default fires on cooldown expiry.
//
// state  | meaning
// IDLE   | no bullet on screen; counting down cooldown, then firing
// FLIGHT | bullet descending one row per tick; hit/miss checked each tick
// OVER   | lives exhausted; no further fire until reset
module enemy_fire #(
  parameter logic [27:0] TICK_COUNT = 28'd2499999,
  parameter logic [7:0]  ENEMY_Y    = 8'd4,
  parameter logic [7:0]  SHIP_Y     = 8'd110,
  parameter logic [7:0]  SHIP_W     = 8'd8,
  parameter logic [7:0]  SCREEN_H   = 8'd119,
  parameter logic [7:0]  FIRE_GAP   = 8'd16
) (
  input logic         i_clock,
  input logic         i_reset,
  enemy_fire_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FLIGHT = 2'd1;
  localparam logic [1:0] OVER   = 2'd2;

  logic [1:0]  r_state;
  logic [27:0] r_tick_cnt;
  logic [7:0]  r_cooldown;
  logic [7:0]  r_x;
  logic [7:0]  r_y;
  logic        r_active;
  logic        r_hit;
  logic [1:0]  r_lives;

  logic       w_tick;
  logic       w_fire_ok;
  logic       w_ship_hit;
  logic [1:0] w_lives_dec;
  logic [8:0] w_x9;
  logic [8:0] w_ship9;

  assign w_tick = bus.i_enable && (r_tick_cnt == 28'd0);

`ifdef RANDOM_FIRE_EN
  logic [7:0] r_lfsr;
  // Fibonacci taps 8,6,5,4; advances every tick regardless of state
  always_ff @(posedge i_clock) begin
    if (i_reset)
      r_lfsr <= 8'hA5;
    else if (w_tick)
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end
  assign w_fire_ok = (r_lfsr[1:0] == 2'b00);
`else
  assign w_fire_ok = 1'b1;
`endif

  // 9-bit compare so a ship near x=255 does not wrap its right edge to 0
  assign w_x9       = {1'b0, r_x};
  assign w_ship9    = {1'b0, bus.i_x_val_ship};
  assign w_ship_hit = (r_y == SHIP_Y) && (w_x9 >= w_ship9) &&
                      (w_x9 < (w_ship9 + {1'b0, SHIP_W}));
  assign w_lives_dec = (r_lives == 2'd0) ? 2'd0 : (r_lives - 2'd1);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_tick_cnt <= TICK_COUNT;
      r_cooldown <= FIRE_GAP;
      r_x        <= 8'd0;
      r_y        <= 8'd0;
      r_active   <= 1'b0;
      r_hit      <= 1'b0;
      r_lives    <= 2'd3;
    end else begin
      r_hit <= 1'b0;
      if (bus.i_enable) begin
        if (r_tick_cnt == 28'd0)
          r_tick_cnt <= TICK_COUNT;
        else
          r_tick_cnt <= r_tick_cnt - 28'd1;
      end
      if (w_tick) begin
        case (r_state)
          IDLE: begin
            if (r_cooldown != 8'd0) begin
              r_cooldown <= r_cooldown - 8'd1;
            end else if (w_fire_ok) begin
              r_x      <= bus.i_x_val_enemy;
              r_y      <= ENEMY_Y;
              r_active <= 1'b1;
              r_state  <= FLIGHT;
            end
          end
          FLIGHT: begin
            // hit is tested first so a ship on the bottom row still wins over a miss
            if (w_ship_hit) begin
              r_hit      <= 1'b1;
              r_lives    <= w_lives_dec;
              r_active   <= 1'b0;
              r_cooldown <= FIRE_GAP;
              r_state    <= (w_lives_dec == 2'd0) ? OVER : IDLE;
            end else if (r_y == SCREEN_H) begin
              r_active   <= 1'b0;
              r_cooldown <= FIRE_GAP;
              r_state    <= IDLE;
            end else begin
              r_y <= r_y + 8'd1;
            end
          end
          OVER:    r_active <= 1'b0;
          default: r_state  <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_x_val_bullet  = r_x;
  assign bus.o_y_val_bullet  = r_y;
  assign bus.o_bullet_active = r_active;
  assign bus.o_hit           = r_hit;
  assign bus.o_lives         = r_lives;
  assign bus.o_game_over     = (r_state == OVER);

endmodule
